priority_encoder_serializer: RTL and testbench
==============================================

// Module: priority_encoder_serializer
// PURPOSE
//  Inverse of the 4-to-16 decoder: takes a multi-hot WIDTH-bit vector and emits the
//  index of every set bit, one per beat, lowest index first (LSB_FIRST=1).
//  Valid/ready on both sides; one vector in flight at a time.
//  Sits between request/flag sources and index-driven consumers (decoder select, mux sel).
// PARAMETERS
//  WIDTH      16  input vector width (power of 2, >=2)
//  IDX_W       4  index width, = log2(WIDTH)
//  LSB_FIRST   1  1: lowest set bit first; 0: highest set bit first
// PORTS
//  clk        in   1       clock, all logic on rising edge
//  rst        in   1       synchronous reset, active-high
//  in_valid   in   1       in_vec valid
//  in_ready   out  1       block accepts a vector this cycle
//  in_vec     in   WIDTH   multi-hot vector to encode
//  out_valid  out  1       out_index/out_last/out_none valid
//  out_ready  in   1       consumer takes current beat
//  out_index  out  IDX_W   index of current set bit
//  out_last   out  1       current beat is final beat of this vector
//  out_none   out  1       captured vector was all-zero (single beat, index 0)
//  busy       out  1       a vector is captured and not fully drained
// BEHAVIOUR
//  Reset (rst=1 at edge): state IDLE, pending=0, in_ready=1 on next cycle;
//   out_valid, out_index, out_last, out_none, busy all 0. Takes priority over all.
//  States: IDLE, EMIT.
//  IDLE: in_ready=1, out_valid=0. in_valid&in_ready -> pending<=in_vec, -> EMIT.
//  EMIT: in_ready=0, out_valid=1, busy=1. Latency: first beat valid the cycle after accept.
//   out_index = priority-selected set bit of pending (per LSB_FIRST); registered outputs.
//   out_last  = 1 when pending has <=1 set bit.
//   out_none  = 1 when pending==0 (zero vector): out_index=0, out_last=1.
//   out_valid&out_ready: clear emitted bit in pending; if out_last -> IDLE, else stay EMIT
//    and next index presented the following cycle (1 beat/cycle with out_ready held high).
//   out_valid&!out_ready: out_index/out_last/out_none held stable; pending unchanged.
//  No bypass: in_ready is 0 through the final beat's handshake cycle; next vector
//   accepted earliest the cycle after return to IDLE (one bubble per vector).
//  Beats per vector = popcount(in_vec), or 1 if in_vec==0. Max WIDTH beats.
//  in_vec ignored while in_ready=0; changes to in_vec after accept have no effect.
//  Reset mid-EMIT: remaining beats discarded, no further out_valid until new accept.
//  No X propagation: outputs defined from reset even with in_vec undriven in IDLE.
// TESTING
//  1 rst held 3 cycles -> out_valid=0, busy=0, in_ready=1, out_index=0.
//  2 in_vec=16'h0010, out_ready=1 -> one beat: index 4, last=1, none=0; in_ready back after.
//  3 in_vec=16'h8001, out_ready=1 -> beats index 0 (last=0) then 15 (last=1), consecutive cycles;
//    with LSB_FIRST=0 -> 15 then 0.
//  4 in_vec=16'h00A0, out_ready low 4 cycles on first beat -> index 5 held stable 4 cycles, then 7.
//  5 in_vec=16'h0000 -> single beat: none=1, index 0, last=1.
//  6 in_vec=16'hFFFF -> 16 beats index 0..15, last only on 15; rst asserted after beat 6 ->
//    out_valid=0 next cycle, new vector 16'h0004 then yields single beat index 2.

Source files
------------

// File: rtl/priority_encoder_serializer.sv
// priority_encoder_serializer: emits the index of every set bit of a captured vector, one per beat
module priority_encoder_serializer #(
  parameter int WIDTH = 16,
  parameter int IDX_W = 4,
  parameter bit LSB_FIRST = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_vec,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [IDX_W-1:0] out_index,
  output logic             out_last,
  output logic             out_none,
  output logic             busy
);
  typedef enum logic {IDLE, EMIT} state_t;
  state_t state;
  logic [WIDTH-1:0] pending, rem, src;
  logic [IDX_W-1:0] idx;
  logic last, none;
  always_comb begin
    rem = pending & ~(WIDTH'(1) << out_index);
    src = (state == IDLE) ? in_vec : rem;
    idx = '0;
    for (int i = 0; i < WIDTH; i++)
      if (src[LSB_FIRST ? WIDTH-1-i : i]) idx = IDX_W'(LSB_FIRST ? WIDTH-1-i : i);
    none = (src == '0);
    last = ((src & (src - WIDTH'(1))) == '0);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      pending   <= '0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      out_index <= '0;
      out_last  <= 1'b0;
      out_none  <= 1'b0;
      busy      <= 1'b0;
    end else if (state == IDLE) begin
      if (in_valid && in_ready) begin
        state     <= EMIT;
        pending   <= in_vec;
        in_ready  <= 1'b0;
        out_valid <= 1'b1;
        busy      <= 1'b1;
        out_index <= idx;
        out_last  <= last;
        out_none  <= none;
      end
    end else if (out_ready) begin
      if (out_last) begin
        state     <= IDLE;
        pending   <= '0;
        in_ready  <= 1'b1;
        out_valid <= 1'b0;
        busy      <= 1'b0;
        out_index <= '0;
        out_last  <= 1'b0;
        out_none  <= 1'b0;
      end else begin
        pending   <= rem;
        out_index <= idx;
        out_last  <= last;
        out_none  <= none;
      end
    end
  end
endmodule

// File: tb/tb_priority_encoder_serializer.sv
// tb_priority_encoder_serializer: randomized checks against a bit-scan reference model
module tb_priority_encoder_serializer;
  logic clk = 0, rst = 1, in_valid = 0, out_ready = 0;
  logic [15:0] in_vec = '0;
  logic in_ready, out_valid, out_last, out_none, busy;
  logic [3:0] out_index;
  logic in_ready2, out_valid2, out_last2, out_none2, busy2;
  logic [3:0] out_index2;
  int checks = 0, errors = 0;
  always #5 clk = ~clk;
  priority_encoder_serializer #(.WIDTH(16), .IDX_W(4), .LSB_FIRST(1)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_vec(in_vec),
    .out_valid(out_valid), .out_ready(out_ready), .out_index(out_index),
    .out_last(out_last), .out_none(out_none), .busy(busy)
  );
  priority_encoder_serializer #(.WIDTH(16), .IDX_W(4), .LSB_FIRST(0)) dut_msb (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready2), .in_vec(in_vec),
    .out_valid(out_valid2), .out_ready(out_ready), .out_index(out_index2),
    .out_last(out_last2), .out_none(out_none2), .busy(busy2)
  );
  function automatic void model(input logic [15:0] v, input bit lsb, output logic [5:0] q[$]);
    logic [5:0] t;
    q = {};
    for (int i = 0; i < 16; i++)
      if (v[i]) begin
        if (lsb) q.push_back({4'(i), 2'b00});
        else q.push_front({4'(i), 2'b00});
      end
    if (q.size() == 0) q.push_back(6'b000011);
    else begin
      t = q.pop_back();
      t[1] = 1'b1;
      q.push_back(t);
    end
  endfunction
  task automatic accept(input logic [15:0] v);
    bit ok = 0;
    @(negedge clk);
    in_valid = 1;
    in_vec = v;
    for (int k = 0; k < 50; k++) begin
      if (in_ready) begin ok = 1; break; end
      @(negedge clk);
    end
    checks++;
    if (!ok) begin errors++; $display("FAIL accept_timeout vec=%h in_ready stayed %b, required 1", v, in_ready); end
    @(posedge clk);
    #1 in_valid = 0;
    in_vec = 16'($urandom);
    @(negedge clk);
  endtask
  task automatic drain(input int pct, output logic [5:0] q[$], output int cyc, output bit ir_seen);
    bit done;
    q = {};
    cyc = 0;
    ir_seen = 0;
    for (int k = 0; k < 300; k++) begin
      out_ready = ($urandom_range(99) < pct);
      if (in_ready) ir_seen = 1;
      if (out_valid && out_ready) q.push_back({out_index, out_last, out_none});
      done = out_valid && out_ready && out_last;
      cyc++;
      @(negedge clk);
      if (done) break;
    end
    out_ready = 0;
  endtask
  task automatic test_reset();
    rst = 1;
    repeat (3) @(posedge clk);
    #1 rst = 0;
    @(negedge clk);
    checks++;
    if ({out_valid, busy, in_ready, out_index, out_last, out_none} !== {3'b001, 4'd0, 2'b00}) begin
      errors++;
      $display("FAIL reset got v=%b busy=%b rdy=%b idx=%0d last=%b none=%b, required 0 0 1 0 0 0", out_valid, busy, in_ready, out_index, out_last, out_none);
    end
    checks++;
    if ({out_valid2, busy2, in_ready2} !== 3'b001) begin errors++; $display("FAIL reset_msb got %b required 001", {out_valid2, busy2, in_ready2}); end
  endtask
  task automatic test_single();
    logic [5:0] q[$];
    int cyc;
    bit irs;
    accept(16'h0010);
    checks++;
    if (out_valid !== 1 || busy !== 1 || in_ready !== 0) begin errors++; $display("FAIL single_latency got v=%b busy=%b rdy=%b required 1 1 0", out_valid, busy, in_ready); end
    drain(100, q, cyc, irs);
    checks++;
    if (q.size() != 1 || q[0] !== {4'd4, 2'b10}) begin errors++; $display("FAIL single_beat got n=%0d first=%b required n=1 %b", q.size(), q.size() ? q[0] : 6'b0, {4'd4, 2'b10}); end
    checks++;
    if (in_ready !== 1 || out_valid !== 0 || busy !== 0) begin errors++; $display("FAIL single_return got rdy=%b v=%b busy=%b required 1 0 0", in_ready, out_valid, busy); end
  endtask
  task automatic test_two();
    accept(16'h8001);
    out_ready = 1;
    checks++;
    if ({out_valid, out_index, out_last, out_none} !== {1'b1, 4'd0, 2'b00}) begin errors++; $display("FAIL two_beat0 got idx=%0d last=%b required 0 0", out_index, out_last); end
    checks++;
    if ({out_valid2, out_index2, out_last2, out_none2} !== {1'b1, 4'd15, 2'b00}) begin errors++; $display("FAIL two_msb_beat0 got idx=%0d last=%b required 15 0", out_index2, out_last2); end
    @(negedge clk);
    checks++;
    if ({out_valid, out_index, out_last, out_none} !== {1'b1, 4'd15, 2'b10}) begin errors++; $display("FAIL two_beat1 got idx=%0d last=%b required 15 1", out_index, out_last); end
    checks++;
    if ({out_valid2, out_index2, out_last2, out_none2} !== {1'b1, 4'd0, 2'b10}) begin errors++; $display("FAIL two_msb_beat1 got idx=%0d last=%b required 0 1", out_index2, out_last2); end
    @(negedge clk);
    out_ready = 0;
    checks++;
    if (in_ready !== 1 || out_valid !== 0 || in_ready2 !== 1) begin errors++; $display("FAIL two_return got rdy=%b v=%b rdy2=%b required 1 0 1", in_ready, out_valid, in_ready2); end
  endtask
  task automatic test_stall();
    accept(16'h00A0);
    out_ready = 0;
    for (int k = 0; k < 4; k++) begin
      checks++;
      if ({out_valid, out_index, out_last, out_none} !== {1'b1, 4'd5, 2'b00}) begin errors++; $display("FAIL stall_hold%0d got v=%b idx=%0d last=%b required 1 5 0", k, out_valid, out_index, out_last); end
      @(negedge clk);
    end
    checks++;
    if ({out_valid, out_index, out_last} !== {1'b1, 4'd5, 1'b0}) begin errors++; $display("FAIL stall_release got idx=%0d required 5", out_index); end
    out_ready = 1;
    @(negedge clk);
    checks++;
    if ({out_valid, out_index, out_last, out_none} !== {1'b1, 4'd7, 2'b10}) begin errors++; $display("FAIL stall_next got idx=%0d last=%b required 7 1", out_index, out_last); end
    @(negedge clk);
    out_ready = 0;
    checks++;
    if (in_ready !== 1 || out_valid !== 0) begin errors++; $display("FAIL stall_return got rdy=%b v=%b required 1 0", in_ready, out_valid); end
  endtask
  task automatic test_zero();
    logic [5:0] q[$];
    int cyc;
    bit irs;
    accept(16'h0000);
    drain(100, q, cyc, irs);
    checks++;
    if (q.size() != 1 || q[0] !== 6'b000011) begin errors++; $display("FAIL zero_beat got n=%0d first=%b required n=1 000011", q.size(), q.size() ? q[0] : 6'b0); end
  endtask
  task automatic test_full_reset();
    logic [5:0] q[$];
    int cyc;
    bit irs;
    accept(16'hFFFF);
    out_ready = 1;
    for (int k = 0; k < 7; k++) begin
      checks++;
      if ({out_valid, out_index, out_last, out_none} !== {1'b1, 4'(k), 2'b00}) begin errors++; $display("FAIL full_beat%0d got v=%b idx=%0d last=%b required 1 %0d 0", k, out_valid, out_index, out_last, k); end
      if (k < 6) @(negedge clk);
    end
    rst = 1;
    @(negedge clk);
    rst = 0;
    out_ready = 0;
    checks++;
    if (out_valid !== 0 || busy !== 0 || in_ready !== 1) begin errors++; $display("FAIL full_reset got v=%b busy=%b rdy=%b required 0 0 1", out_valid, busy, in_ready); end
    repeat (2) @(negedge clk);
    checks++;
    if (out_valid !== 0) begin errors++; $display("FAIL full_quiet got v=%b required 0", out_valid); end
    accept(16'h0004);
    drain(100, q, cyc, irs);
    checks++;
    if (q.size() != 1 || q[0] !== {4'd2, 2'b10}) begin errors++; $display("FAIL full_after got n=%0d first=%b required n=1 %b", q.size(), q.size() ? q[0] : 6'b0, {4'd2, 2'b10}); end
  endtask
  task automatic test_random();
    logic [5:0] q[$], e[$];
    logic [15:0] v;
    int cyc;
    bit irs;
    for (int n = 0; n < 30; n++) begin
      v = 16'($urandom);
      if (n % 3 == 1) v = v & 16'($urandom) & 16'($urandom);
      accept(v);
      drain($urandom_range(100, 30), q, cyc, irs);
      model(v, 1, e);
      checks++;
      if (q != e) begin errors++; $display("FAIL random vec=%h got %0d beats first=%b required %0d beats first=%b", v, q.size(), q.size() ? q[0] : 6'b0, e.size(), e[0]); end
      checks++;
      if (irs !== 0) begin errors++; $display("FAIL random_ready vec=%h in_ready seen high during emit, required 0", v); end
    end
  endtask
  task automatic test_back_to_back();
    logic [5:0] q[$], e[$];
    logic [15:0] v;
    int cyc;
    bit irs;
    for (int n = 0; n < 8; n++) begin
      v = 16'($urandom);
      accept(v);
      drain(100, q, cyc, irs);
      model(v, 1, e);
      checks++;
      if (q != e || cyc != e.size()) begin errors++; $display("FAIL b2b vec=%h got %0d beats in %0d cycles required %0d in %0d", v, q.size(), cyc, e.size(), e.size()); end
    end
  endtask
  initial begin
    test_reset();
    test_single();
    test_two();
    test_stall();
    test_zero();
    test_full_reset();
    test_random();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
